// File: rtl/pseudo_linear_mc_trainer_if.sv
// Sample/result handshake and parameter readback bundle for pseudo_linear_mc_trainer.
// err_cnt is present only when PL_ERR_CNT_EN is defined.
interface pseudo_linear_mc_trainer_if #(
  parameter int N_FEAT  = 784,
  parameter int N_CLASS = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [N_FEAT-1:0]  feat;
  logic [3:0]         label;
  logic               train_en;
  logic [3:0]         threshold;
  logic               out_valid;
  logic               out_ready;
  logic [N_CLASS-1:0] pred;
  logic [N_CLASS-1:0] err;
  logic [3:0]         pm_sel;
  logic [N_FEAT-1:0]  pm;
`ifdef PL_ERR_CNT_EN
  logic [15:0]        err_cnt;

  modport master (
    output in_valid, feat, label, train_en, threshold, out_ready, pm_sel,
    input  in_ready, out_valid, pred, err, pm, err_cnt
  );
  modport slave (
    input  in_valid, feat, label, train_en, threshold, out_ready, pm_sel,
    output in_ready, out_valid, pred, err, pm, err_cnt
  );
`else
  modport master (
    output in_valid, feat, label, train_en, threshold, out_ready, pm_sel,
    input  in_ready, out_valid, pred, err, pm
  );
  modport slave (
    input  in_valid, feat, label, train_en, threshold, out_ready, pm_sel,
    output in_ready, out_valid, pred, err, pm
  );
`endif
endinterface

// File: rtl/pseudo_linear_mc_trainer.sv
// One-vs-rest binary pseudo-linear classifier/trainer, CHUNK feature bits per cycle (PL_ERR_CNT_EN adds err_cnt).
// Latency: out_valid at cycle NC+2 after accept, 2*NC+2 when an update pass runs.
// Backpressure: one sample in flight; in_ready only in IDLE, result held in DONE until out_ready.
module pseudo_linear_mc_trainer #(
  parameter int N_FEAT  = 784,
  parameter int N_CLASS = 10,
  parameter int CHUNK   = 16,
  parameter int CNT_W   = 10
) (
  input logic                     clk,
  input logic                     rst,
  pseudo_linear_mc_trainer_if.slave bus
);
  localparam int NC = N_FEAT / CHUNK;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [2:0] {IDLE, COUNT, DECIDE, UPDATE, DONE} state_t;
  state_t state, state_nx;

  logic [N_CLASS-1:0][N_FEAT-1:0] p;
  logic [N_CLASS-1:0][CNT_W-1:0]  num, num_p;
  logic [N_FEAT-1:0]              feat_q;
  logic [3:0]                     label_q, thr_q;
  logic                           train_q;
  logic [KW-1:0]                  k;
  logic                           last_chunk;
  logic [N_CLASS-1:0]             pred_q, err_q, pred_d, err_d;
  logic [CHUNK-1:0]               f_chunk;
  logic [N_CLASS-1:0][CHUNK-1:0]  p_chunk, p_chunk_upd;
  logic                           in_ready_w, out_valid_w;
  logic [N_FEAT-1:0]              pm_w;

  function automatic logic [CNT_W-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  function automatic logic fwd(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] np,
                               input logic [3:0] thr);
    return ((np >> thr) >= n) ? 1'b0 : 1'b1;
  endfunction

  // Would flipping this bit move the class output away from the current prediction?
  function automatic logic flips(input logic pb, input logic fb,
                                 input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] np,
                                 input logic [3:0] thr, input logic pr);
    logic [CNT_W-1:0] n_r, np_r;
    n_r  = fb ? (pb ? n - CNT_W'(1) : n + CNT_W'(1)) : n;
    np_r = pb ? np - CNT_W'(1) : np + CNT_W'(1);
    return fwd(n_r, np_r, thr) != pr;
  endfunction

  assign last_chunk = (k == KW'(NC - 1));
  assign f_chunk    = feat_q[int'(k)*CHUNK +: CHUNK];

  always_comb begin
    p_chunk = '0;
    for (int c = 0; c < N_CLASS; c++) p_chunk[c] = p[c][int'(k)*CHUNK +: CHUNK];
  end

  always_comb begin
    pred_d = '0;
    err_d  = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      pred_d[c] = fwd(num[c], num_p[c], thr_q);
      err_d[c]  = pred_d[c] ^ (int'(label_q) == c);
    end
  end

  // num/num_p stay frozen from DECIDE, so every bit of the pass sees the same counts.
  always_comb begin
    p_chunk_upd = p_chunk;
    for (int c = 0; c < N_CLASS; c++) begin
      if (err_q[c]) begin
        for (int b = 0; b < CHUNK; b++) begin
          if (flips(p_chunk[c][b], f_chunk[b], num[c], num_p[c], thr_q, pred_q[c]))
            p_chunk_upd[c][b] = ~p_chunk[c][b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state)
      IDLE: begin
        in_ready_w = 1'b1;
        if (bus.in_valid) state_nx = COUNT;
      end
      COUNT:  if (last_chunk) state_nx = DECIDE;
      DECIDE: state_nx = (train_q && (err_d != '0)) ? UPDATE : DONE;
      UPDATE: if (last_chunk) state_nx = DONE;
      DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p       <= '0;
      num     <= '0;
      num_p   <= '0;
      pred_q  <= '0;
      err_q   <= '0;
      k       <= '0;
      feat_q  <= '0;
      label_q <= '0;
      thr_q   <= '0;
      train_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat_q  <= bus.feat;
            label_q <= bus.label;
            thr_q   <= bus.threshold;
            train_q <= bus.train_en;
            num     <= '0;
            num_p   <= '0;
            k       <= '0;
          end
        end
        COUNT: begin
          for (int c = 0; c < N_CLASS; c++) begin
            num[c]   <= num[c] + popcnt(p_chunk[c] & f_chunk);
            num_p[c] <= num_p[c] + popcnt(p_chunk[c]);
          end
          k <= last_chunk ? '0 : k + KW'(1);
        end
        DECIDE: begin
          pred_q <= pred_d;
          err_q  <= err_d;
          k      <= '0;
        end
        UPDATE: begin
          for (int c = 0; c < N_CLASS; c++) p[c][int'(k)*CHUNK +: CHUNK] <= p_chunk_upd[c];
          k <= last_chunk ? '0 : k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pm_w = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      if (int'(bus.pm_sel) == c) pm_w = p[c];
    end
  end

`ifdef PL_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else if (state == DONE && bus.out_ready && (err_q != '0) && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.pred      = pred_q;
  assign bus.err       = err_q;
  assign bus.pm        = pm_w;
endmodule

// File: tb/tb_pseudo_linear_mc_trainer.sv
// Scoreboarded bench for pseudo_linear_mc_trainer: a behavioural model predicts pred/err/latency
// and parameter state per sample; results are popped and compared when out_valid appears.
module tb_pseudo_linear_mc_trainer;
  localparam int N_FEAT  = 784;
  localparam int N_CLASS = 10;
  localparam int CHUNK   = 16;
  localparam int CNT_W   = 10;
  localparam int NC      = N_FEAT / CHUNK;

  typedef struct {
    logic [N_CLASS-1:0] pred;
    logic [N_CLASS-1:0] err;
    int                 lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pseudo_linear_mc_trainer_if #(.N_FEAT(N_FEAT), .N_CLASS(N_CLASS)) ifc ();

  pseudo_linear_mc_trainer #(
    .N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .CHUNK(CHUNK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [N_FEAT-1:0] p_m [N_CLASS];
  logic [15:0] err_cnt_m;

  task automatic chk(input string tag, input logic [N_FEAT-1:0] got, input logic [N_FEAT-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N_CLASS; c++) p_m[c] = '0;
    err_cnt_m = '0;
    sb.delete();
  endtask

  // Reference behaviour over the whole vector: count, decide, then optional one-vs-rest update.
  task automatic model_step(input logic [N_FEAT-1:0] f, input logic [3:0] lbl,
                            input logic tr, input logic [3:0] th);
    exp_t e;
    int nv[N_CLASS];
    int npv[N_CLASS];
    int nr, npr;
    logic pb, fo;
    for (int c = 0; c < N_CLASS; c++) begin
      nv[c] = 0;
      npv[c] = 0;
      for (int m = 0; m < N_FEAT; m++) begin
        if (p_m[c][m]) begin
          npv[c]++;
          if (f[m]) nv[c]++;
        end
      end
      e.pred[c] = ((npv[c] >> th) >= nv[c]) ? 1'b0 : 1'b1;
      e.err[c]  = e.pred[c] ^ (int'(lbl) == c);
    end
    e.lat = (tr && e.err != '0) ? 2*NC + 2 : NC + 2;
    if (tr && e.err != '0) begin
      for (int c = 0; c < N_CLASS; c++) begin
        if (e.err[c]) begin
          for (int m = 0; m < N_FEAT; m++) begin
            pb  = p_m[c][m];
            nr  = f[m] ? (pb ? nv[c] - 1 : nv[c] + 1) : nv[c];
            npr = pb ? npv[c] - 1 : npv[c] + 1;
            fo  = ((npr >> th) >= nr) ? 1'b0 : 1'b1;
            if (fo != e.pred[c]) p_m[c][m] = ~pb;
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  function automatic logic [N_FEAT-1:0] rand_feat(input int density);
    logic [N_FEAT-1:0] v;
    for (int m = 0; m < N_FEAT; m++) v[m] = ($urandom_range(0, density - 1) == 0);
    return v;
  endfunction

  task automatic check_pm(input string tag);
    for (int s = 0; s < N_CLASS; s++) begin
      ifc.pm_sel = 4'(s);
      @(posedge clk); #1;
      chk($sformatf("%s_c%0d", tag, s), ifc.pm, p_m[s]);
    end
    ifc.pm_sel = 4'd15;
    @(posedge clk); #1;
    chk({tag, "_oob"}, ifc.pm, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Entry/exit point: 1 time unit after a rising edge with the DUT idle.
  task automatic run_sample(input logic [N_FEAT-1:0] f, input logic [3:0] lbl,
                            input logic tr, input logic [3:0] th, input int hold);
    exp_t e;
    int   lat;
    bit   got;
    bit   stable;
    model_step(f, lbl, tr, th);
    chk("idle_in_ready", ifc.in_ready, 1);
    ifc.feat = f; ifc.label = lbl; ifc.train_en = tr; ifc.threshold = th;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.feat = ~f; ifc.label = lbl + 4'd1; ifc.train_en = ~tr; ifc.threshold = ~th;
    chk("busy_in_ready", ifc.in_ready, 0);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 3*NC + 10 && !got; i++) begin
      if (ifc.out_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("latency", lat, e.lat);
    chk("pred", ifc.pred, e.pred);
    chk("err", ifc.err, e.err);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!ifc.out_valid || ifc.in_ready || ifc.pred !== e.pred || ifc.err !== e.err) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk("post_in_ready", ifc.in_ready, 1);
    chk("post_out_valid", ifc.out_valid, 0);
    chk("post_pred_kept", ifc.pred, e.pred);
`ifdef PL_ERR_CNT_EN
    if (e.err != '0 && err_cnt_m != 16'hFFFF) err_cnt_m = err_cnt_m + 16'd1;
    chk("err_cnt", ifc.err_cnt, err_cnt_m);
`endif
  endtask

  initial begin
    logic [N_FEAT-1:0] f0f;
    bit saw_ov;
    f0f = '0;
    f0f[3:0] = 4'hF;
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.feat = '0; ifc.label = '0; ifc.train_en = 1'b0;
    ifc.threshold = '0; ifc.out_ready = 1'b0; ifc.pm_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_pred", ifc.pred, 0);
    chk("rst_err", ifc.err, 0);
`ifdef PL_ERR_CNT_EN
    chk("rst_err_cnt", ifc.err_cnt, 0);
`endif
    check_pm("rst_pm");

    // Learn class 3 from an empty model, then the repeat is classified correctly.
    run_sample(f0f, 4'd3, 1'b1, 4'd1, 0);
    check_pm("learn_pm");
    run_sample(f0f, 4'd3, 1'b1, 4'd1, 0);
    check_pm("repeat_pm");

    // threshold 0: error present but no bit flips
    do_reset();
    run_sample(f0f, 4'd3, 1'b1, 4'd0, 0);
    check_pm("thr0_pm");

    // inference only, then a long output stall
    run_sample(f0f, 4'd3, 1'b0, 4'd1, 0);
    run_sample(f0f, 4'd5, 1'b0, 4'd1, 20);

    // random training mix, labels including out-of-range targets
    for (int i = 0; i < 8; i++)
      run_sample(rand_feat(4), 4'($urandom_range(0, 11)), 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 3)), (i == 3) ? 3 : 0);
    run_sample(rand_feat(2), 4'd12, 1'b1, 4'd2, 0);
    check_pm("rand_pm");

    // reset in the middle of an update pass
    do_reset();
    ifc.feat = f0f; ifc.label = 4'd3; ifc.train_en = 1'b1; ifc.threshold = 4'd1;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    chk("abort_pre_out_valid", ifc.out_valid, 0);
    do_reset();
    chk("abort_in_ready", ifc.in_ready, 1);
    chk("abort_out_valid", ifc.out_valid, 0);
`ifdef PL_ERR_CNT_EN
    chk("abort_err_cnt", ifc.err_cnt, 0);
`endif
    saw_ov = 1'b0;
    for (int i = 0; i < 2*NC + 10; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) saw_ov = 1'b1;
    end
    chk("abort_no_output", saw_ov, 0);
    check_pm("abort_pm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pseudo_linear_mc_trainer.md
PSEUDO_LINEAR_MC_TRAINER -- requirements
Module: pseudo_linear_mc_trainer

Interface
REQ-001 SHALL have parameter N_FEAT, default 784: feature bits per sample.
REQ-002 SHALL have parameter N_CLASS, default 10: one-vs-rest class lanes.
REQ-003 SHALL have parameter CHUNK, default 16: feature bits processed per cycle; N_FEAT % CHUNK == 0 is required. NC = N_FEAT/CHUNK.
REQ-004 SHALL have parameter CNT_W, default 10: popcount width, at least clog2(N_FEAT+1).
REQ-005 clk  in  1  sole clock; all state on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  sample offered.
REQ-008 in_ready  out  1  block can accept a sample.
REQ-009 feat  in  N_FEAT  sample bit vector.
REQ-010 label  in  4  true class index.
REQ-011 train_en  in  1  1 = update parameters on error; 0 = inference only.
REQ-012 threshold  in  4  right-shift applied to the parameter popcount.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 pred  out  N_CLASS  per-class forward output.
REQ-016 err  out  N_CLASS  per-class error, pred[c] XOR (label==c).
REQ-017 pm_sel  in  4  class select for parameter readback.
REQ-018 pm  out  N_FEAT  combinational readback of p[pm_sel]; zero if pm_sel >= N_CLASS.

Function
REQ-019 SHALL hold one N_FEAT-bit parameter vector p[c] per class.
REQ-020 SHALL run an FSM with states IDLE -> COUNT -> DECIDE -> (UPDATE) -> DONE -> IDLE.
- in_ready = 1 only in IDLE.
REQ-021 SHALL capture feat, label, train_en and threshold on in_valid & in_ready.
- Later input changes SHALL have no effect on the sample in flight.
REQ-022 COUNT SHALL last NC cycles; chunk k = bits [k*CHUNK +: CHUNK].
- Per class, each cycle accumulates num[c] += popcount(p[c] & feat chunk) and num_p[c] += popcount(p[c] chunk).
REQ-023 DECIDE SHALL last 1 cycle and compute, per class, pred[c] = 0 if (num_p[c] >> threshold) >= num[c], else 1.
- Comparison is unsigned, CNT_W bits.
- err[c] is also computed in DECIDE.
REQ-024 If train_en = 1 and err != 0, DECIDE SHALL go to UPDATE; otherwise it SHALL go to DONE.
REQ-025 UPDATE SHALL last NC cycles, one chunk per cycle, for every class with err[c] = 1.
- num_r = feat[m] ? (p[c][m] ? num-1 : num+1) : num
- num_p_r = p[c][m] ? num_p-1 : num_p+1
- p[c][m] flips iff forward(num_r, num_p_r) != pred[c].
REQ-026 UPDATE SHALL use the num/num_p frozen at DECIDE; it SHALL NOT recount mid-pass.
- Classes with err[c] = 0 SHALL be unchanged.
REQ-027 DONE SHALL hold out_valid = 1 with pred/err stable until out_ready = 1, then return to IDLE.
- in_ready rises the following cycle.
REQ-028 Latency, with accept at cycle 0:
- out_valid first high at cycle NC+2 without update.
- out_valid first high at cycle 2*NC+2 with update.
REQ-029 label >= N_CLASS SHALL give an all-zero target vector.
REQ-030 pred and err SHALL retain their last values outside DONE.

Reset
REQ-031 rst SHALL, on the next edge:
- clear every p[c], pred, err, num and num_p;
- force IDLE, out_valid = 0, in_ready = 1.
REQ-032 rst during COUNT or UPDATE SHALL abort the sample with no output.
- The partial parameter update is discarded because p is cleared.

Configuration
REQ-033 Macro PL_ERR_CNT_EN defined SHALL add output err_cnt (16 bits).
- Increments by 1 on every DONE handshake where err != 0.
- Saturates at 0xFFFF; cleared by rst.
REQ-034 Without PL_ERR_CNT_EN, no err_cnt port or logic SHALL exist; all other behaviour is identical.

Verification (defaults: N_FEAT=784, CHUNK=16, NC=49)
REQ-035 Reset, sample feat = 0x0F (bits 0-3), label = 3, train_en = 1, threshold = 1 -> pred = 0, err = 0x008, out_valid at cycle 100; pm_sel = 3 afterwards reads 0x0F; other classes stay 0.
REQ-036 Repeat same sample -> num[3] = 4, num_p[3] = 4, (4>>1) < 4 -> pred = 0x008, err = 0, out_valid at cycle 51, p unchanged.
REQ-037 Reset, same sample with threshold = 0 -> class 3 err = 1 but forward(1,1) = 0 = pred, so no flips; p[3] stays 0; out_valid at cycle 100.
REQ-038 train_en = 0, label = 3, p = 0 -> err = 0x008, no UPDATE, out_valid at cycle 51, all p unchanged.
REQ-039 out_ready held 0 for 20 cycles in DONE -> out_valid, pred and err stable, in_ready = 0; in_ready = 1 the cycle after out_ready rises.
REQ-040 rst asserted at cycle 60 of an update pass -> IDLE next cycle, no out_valid, all p = 0; with PL_ERR_CNT_EN, err_cnt = 0.
